// File: rtl/imem_arbiter.sv
// Two-port (fetch/debug) round-robin arbiter onto one synchronous instruction RAM with address-fault screening.
// Grant is combinational with requests; responses arrive one cycle after grant; losers see gnt=0 (fetch also sees f_stall).
module imem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          AW        = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [31:0]   f_rdata,
  output logic          f_err,
  output logic          f_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [32:0] LIMIT = 33'd4 << AW;

  // last_winner: 1 = debug won the most recent contended cycle
  logic last_winner_q, last_winner_d;
  logic rsp_vld_q, rsp_vld_d;
  logic rsp_dbg_q, rsp_dbg_d;
  logic rsp_read_q, rsp_read_d;
  logic rsp_fault_q, rsp_fault_d;

  logic        any_gnt;
  logic [31:0] sel_addr;
  logic [31:0] sel_off;
  logic        sel_fault;
  logic        rsp_live;
  logic [31:0] rsp_dat;

  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (f_req && d_req) begin
        f_gnt = last_winner_q;
        d_gnt = ~last_winner_q;
      end else begin
        f_gnt = f_req;
        d_gnt = d_req;
      end
    end
  end

  assign f_stall   = f_req & ~f_gnt;
  assign any_gnt   = f_gnt | d_gnt;
  assign sel_addr  = d_gnt ? d_addr : f_addr;
  assign sel_off   = sel_addr - BASE_ADDR;
  assign sel_fault = (sel_addr < BASE_ADDR) || ({1'b0, sel_off} >= LIMIT) || (sel_addr[1:0] != 2'b00);

  assign mem_en    = any_gnt & ~sel_fault;
  assign mem_we    = d_gnt & d_we & ~sel_fault;
  assign mem_addr  = any_gnt ? sel_off[AW+1:2] : '0;
  assign mem_wdata = d_gnt ? d_wdata : 32'h0;

  always_comb begin
    last_winner_d = last_winner_q;
    if (f_req && d_req && !reset) begin
      last_winner_d = d_gnt;
    end
    rsp_vld_d   = any_gnt;
    rsp_dbg_d   = d_gnt;
    rsp_read_d  = ~(d_gnt & d_we);
    rsp_fault_d = sel_fault;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_q <= 1'b1;
      rsp_vld_q     <= 1'b0;
      rsp_dbg_q     <= 1'b0;
      rsp_read_q    <= 1'b0;
      rsp_fault_q   <= 1'b0;
    end else begin
      last_winner_q <= last_winner_d;
      rsp_vld_q     <= rsp_vld_d;
      rsp_dbg_q     <= rsp_dbg_d;
      rsp_read_q    <= rsp_read_d;
      rsp_fault_q   <= rsp_fault_d;
    end
  end

  // A response landing in a reset cycle is dropped, not merely delayed
  assign rsp_live = rsp_vld_q & ~reset;
  assign rsp_dat  = (rsp_read_q && !rsp_fault_q) ? mem_rdata : 32'h0;

  assign f_rvalid = rsp_live & ~rsp_dbg_q;
  assign d_rvalid = rsp_live & rsp_dbg_q;
  assign f_rdata  = f_rvalid ? rsp_dat : 32'h0;
  assign d_rdata  = d_rvalid ? rsp_dat : 32'h0;
  assign f_err    = f_rvalid & rsp_fault_q;
  assign d_err    = d_rvalid & rsp_fault_q;

endmodule
